// File: rtl/stand_cell_pkg.sv
// Shared types and constants for the standard-cell propagation delay meter.
package stand_cell_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WFALL,
        WRISE
    } state_t;

    localparam int CW_DEFAULT   = 12;
    localparam int TOUT_DEFAULT = 4000;
    localparam int TICK_NS      = 10;

endpackage

// File: rtl/stand_cell_stat.sv
// Last and worst-case delay holder for one propagation direction.
module stand_cell_stat
    import stand_cell_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          U,
    input  logic          RESET,
    input  logic          CLR,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic [CW-1:0] last,
    output logic [CW-1:0] peak
);

    // A completion on the same tick as a clear wins: the clear only zeroes
    // what the completion is not about to overwrite.
    always_ff @(posedge U) begin
        if (RESET) begin
            last <= '0;
            peak <= '0;
        end else if (load) begin
            last <= value;
            if (CLR || value > peak) begin
                peak <= value;
            end
        end else if (CLR) begin
            last <= '0;
            peak <= '0;
        end
    end

endmodule

// File: rtl/stand_cell_meter.sv
// Times D -> _Q propagation of a standard cell in clock ticks and keeps
// per-direction last/max delays plus timeout, abort and spurious-edge flags.
module stand_cell_meter
    import stand_cell_pkg::*;
#(
    parameter int CW   = CW_DEFAULT,
    parameter int TOUT = TOUT_DEFAULT
) (
    input  logic          U,
    input  logic          RESET,
    input  logic          D,
    input  logic          _Q,
    input  logic          CLR,
    output logic [CW-1:0] FALL_LAST,
    output logic [CW-1:0] FALL_MAX,
    output logic [CW-1:0] RISE_LAST,
    output logic [CW-1:0] RISE_MAX,
    output logic [15:0]   NMEAS,
    output logic          BUSY,
    output logic          TMO,
    output logic          ABORT,
    output logic          SPUR
);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          d_s, d_p, q_s, q_p;
    logic          d_edge, q_fall, q_rise;
    logic          done, wrong;
    logic          fall_done, rise_done;
    logic          set_tmo, set_abort, set_spur;

    assign d_edge = d_s ^ d_p;
    assign q_fall = q_p & ~q_s;
    assign q_rise = ~q_p & q_s;

    // The response must finish before a new D edge is interpreted, so a
    // completion and a D edge on the same tick chain into a fresh wait.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done      = 1'b0;
        wrong     = 1'b0;
        fall_done = 1'b0;
        rise_done = 1'b0;
        set_tmo   = 1'b0;
        set_abort = 1'b0;
        set_spur  = 1'b0;
        case (state)
            IDLE: begin
                set_spur = q_fall | q_rise;
                if (d_edge) begin
                    state_nxt = d_s ? WFALL : WRISE;
                    cnt_nxt   = CW'(1);
                end
            end
            WFALL, WRISE: begin
                done     = (state == WFALL) ? q_fall : q_rise;
                wrong    = (state == WFALL) ? q_rise : q_fall;
                set_spur = wrong;
                if (cnt != '1) begin
                    cnt_nxt = cnt + CW'(1);
                end
                if (done) begin
                    fall_done = (state == WFALL);
                    rise_done = (state == WRISE);
                    if (d_edge) begin
                        state_nxt = d_s ? WFALL : WRISE;
                        cnt_nxt   = CW'(1);
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end else if (d_edge) begin
                    set_abort = 1'b1;
                    state_nxt = d_s ? WFALL : WRISE;
                    cnt_nxt   = CW'(1);
                end else if (cnt == CW'(TOUT)) begin
                    set_tmo   = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Samplers load the live pins during reset so release never looks like an edge.
    always_ff @(posedge U) begin
        if (RESET) begin
            d_s   <= D;
            d_p   <= D;
            q_s   <= _Q;
            q_p   <= _Q;
            state <= IDLE;
            cnt   <= '0;
            NMEAS <= '0;
            TMO   <= 1'b0;
            ABORT <= 1'b0;
            SPUR  <= 1'b0;
        end else begin
            d_p   <= d_s;
            d_s   <= D;
            q_p   <= q_s;
            q_s   <= _Q;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            NMEAS <= (CLR ? 16'd0 : NMEAS) + {15'd0, fall_done | rise_done};
            TMO   <= (TMO   & ~CLR) | set_tmo;
            ABORT <= (ABORT & ~CLR) | set_abort;
            SPUR  <= (SPUR  & ~CLR) | set_spur;
        end
    end

    assign BUSY = (state == WFALL) || (state == WRISE);

    stand_cell_stat #(.CW(CW)) u_fall (
        .U     (U),
        .RESET (RESET),
        .CLR   (CLR),
        .load  (fall_done),
        .value (cnt),
        .last  (FALL_LAST),
        .peak  (FALL_MAX)
    );

    stand_cell_stat #(.CW(CW)) u_rise (
        .U     (U),
        .RESET (RESET),
        .CLR   (CLR),
        .load  (rise_done),
        .value (cnt),
        .last  (RISE_LAST),
        .peak  (RISE_MAX)
    );

endmodule

// File: tb/tb_stand_cell_meter.sv
// Directed bench for stand_cell_meter: _Q is driven by hand a chosen number
// of ticks after each D change, so every expected delay is known exactly.
module tb_stand_cell_meter;
    import stand_cell_pkg::*;

    localparam int CW   = 12;
    localparam int TOUT = 4000;

    logic          U = 1'b0;
    logic          RESET, D, _Q, CLR;
    logic [CW-1:0] FALL_LAST, FALL_MAX, RISE_LAST, RISE_MAX;
    logic [15:0]   NMEAS;
    logic          BUSY, TMO, ABORT, SPUR;

    int vectors     = 0;
    int miscompares = 0;

    stand_cell_meter #(.CW(CW), .TOUT(TOUT)) dut (
        .U         (U),
        .RESET     (RESET),
        .D         (D),
        ._Q        (_Q),
        .CLR       (CLR),
        .FALL_LAST (FALL_LAST),
        .FALL_MAX  (FALL_MAX),
        .RISE_LAST (RISE_LAST),
        .RISE_MAX  (RISE_MAX),
        .NMEAS     (NMEAS),
        .BUSY      (BUSY),
        .TMO       (TMO),
        .ABORT     (ABORT),
        .SPUR      (SPUR)
    );

    always #(TICK_NS / 2) U = ~U;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    // Change D, then answer on _Q exactly 'delay' ticks later and let results settle.
    task automatic applyStimulus(input logic newD, input int delay);
        D = newD;
        repeat (delay) @(negedge U);
        _Q = ~newD;
        repeat (3) @(negedge U);
    endtask

    initial begin
        RESET = 1'b1;
        D     = 1'b0;
        _Q    = 1'b1;
        CLR   = 1'b0;
        repeat (3) @(negedge U);
        checkOutput("rst_fall_last", 32'(FALL_LAST), 0);
        checkOutput("rst_rise_max", 32'(RISE_MAX), 0);
        checkOutput("rst_nmeas", 32'(NMEAS), 0);
        checkOutput("rst_busy", 32'(BUSY), 0);
        checkOutput("rst_flags", {29'd0, TMO, ABORT, SPUR}, 0);
        RESET = 1'b0;
        repeat (2) @(negedge U);
        checkOutput("post_rst_spur", 32'(SPUR), 0);

        applyStimulus(1'b1, 31);
        checkOutput("fall_last_31", 32'(FALL_LAST), 31);
        checkOutput("fall_max_31", 32'(FALL_MAX), 31);
        checkOutput("nmeas_1", 32'(NMEAS), 1);
        checkOutput("flags_clean", {29'd0, TMO, ABORT, SPUR}, 0);

        applyStimulus(1'b0, 301);
        checkOutput("rise_last_301", 32'(RISE_LAST), 301);
        checkOutput("rise_max_301", 32'(RISE_MAX), 301);
        checkOutput("nmeas_2", 32'(NMEAS), 2);

        applyStimulus(1'b1, 5);
        checkOutput("fall_last_5", 32'(FALL_LAST), 5);
        checkOutput("fall_max_kept", 32'(FALL_MAX), 31);
        applyStimulus(1'b0, 40);
        checkOutput("rise_last_40", 32'(RISE_LAST), 40);
        checkOutput("rise_max_kept", 32'(RISE_MAX), 301);
        checkOutput("nmeas_4", 32'(NMEAS), 4);

        // Abort, then a wrong-direction glitch during the restarted wait.
        D = 1'b1;
        repeat (10) @(negedge U);
        D = 1'b0;
        repeat (5) @(negedge U);
        checkOutput("abort_set", 32'(ABORT), 1);
        checkOutput("abort_busy", 32'(BUSY), 1);
        _Q = 1'b0;
        repeat (15) @(negedge U);
        checkOutput("wrong_dir_spur", 32'(SPUR), 1);
        checkOutput("wrong_dir_busy", 32'(BUSY), 1);
        _Q = 1'b1;
        repeat (3) @(negedge U);
        checkOutput("abort_rise_last", 32'(RISE_LAST), 20);
        checkOutput("abort_fall_last", 32'(FALL_LAST), 5);
        checkOutput("abort_nmeas", 32'(NMEAS), 5);
        checkOutput("abort_idle", 32'(BUSY), 0);

        CLR = 1'b1;
        @(negedge U);
        CLR = 1'b0;
        repeat (2) @(negedge U);
        checkOutput("clr_stats", 32'(FALL_LAST | FALL_MAX | RISE_LAST | RISE_MAX), 0);
        checkOutput("clr_nmeas", 32'(NMEAS), 0);
        checkOutput("clr_flags", {29'd0, TMO, ABORT, SPUR}, 0);

        _Q = 1'b0;
        repeat (3) @(negedge U);
        checkOutput("idle_spur", 32'(SPUR), 1);
        checkOutput("idle_spur_busy", 32'(BUSY), 0);
        _Q = 1'b1;
        repeat (3) @(negedge U);

        // CLR lands on the completing edge: completion values survive.
        D = 1'b1;
        repeat (7) @(negedge U);
        _Q = 1'b0;
        @(negedge U);
        CLR = 1'b1;
        @(negedge U);
        CLR = 1'b0;
        repeat (2) @(negedge U);
        checkOutput("clrdone_fall_last", 32'(FALL_LAST), 7);
        checkOutput("clrdone_fall_max", 32'(FALL_MAX), 7);
        checkOutput("clrdone_nmeas", 32'(NMEAS), 1);
        checkOutput("clrdone_spur", 32'(SPUR), 0);

        // Response and a new D edge on the same tick: no abort, chained wait.
        D = 1'b0;
        repeat (12) @(negedge U);
        _Q = 1'b1;
        D  = 1'b1;
        repeat (4) @(negedge U);
        checkOutput("chain_rise_last", 32'(RISE_LAST), 12);
        checkOutput("chain_busy", 32'(BUSY), 1);
        checkOutput("chain_no_abort", 32'(ABORT), 0);
        repeat (5) @(negedge U);
        _Q = 1'b0;
        repeat (3) @(negedge U);
        checkOutput("chain_fall_last", 32'(FALL_LAST), 9);
        checkOutput("chain_fall_max", 32'(FALL_MAX), 9);
        checkOutput("chain_nmeas", 32'(NMEAS), 3);

        applyStimulus(1'b0, 1);
        checkOutput("min_rise_last", 32'(RISE_LAST), 1);
        checkOutput("min_rise_max", 32'(RISE_MAX), 12);
        checkOutput("min_nmeas", 32'(NMEAS), 4);

        // _Q stuck high after D rises: wait runs out at cnt == TOUT.
        D = 1'b1;
        repeat (TOUT + 1) @(negedge U);
        checkOutput("tmo_not_yet", 32'(TMO), 0);
        checkOutput("tmo_still_busy", 32'(BUSY), 1);
        @(negedge U);
        checkOutput("tmo_set", 32'(TMO), 1);
        checkOutput("tmo_busy_fall", 32'(BUSY), 0);
        checkOutput("tmo_nmeas", 32'(NMEAS), 4);
        checkOutput("tmo_fall_last", 32'(FALL_LAST), 9);

        // Reset in the middle of a rise wait; _Q moves while reset is held.
        _Q = 1'b0;
        repeat (2) @(negedge U);
        D = 1'b0;
        repeat (100) @(negedge U);
        checkOutput("pre_rst_busy", 32'(BUSY), 1);
        RESET = 1'b1;
        @(negedge U);
        checkOutput("midrst_busy", 32'(BUSY), 0);
        checkOutput("midrst_flags", {29'd0, TMO, ABORT, SPUR}, 0);
        checkOutput("midrst_nmeas", 32'(NMEAS), 0);
        _Q = 1'b1;
        @(negedge U);
        RESET = 1'b0;
        repeat (3) @(negedge U);
        checkOutput("after_rst_spur", 32'(SPUR), 0);
        checkOutput("after_rst_busy", 32'(BUSY), 0);
        checkOutput("after_rst_stats", 32'(FALL_LAST | FALL_MAX | RISE_LAST | RISE_MAX), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
